axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Packet-aware round-robin arbiter that shares one 33-bit stream channel between `NUM_PORTS` requesters. Grant locks on a requester at packet start and releases only after the beat carrying `last` (data bit `DW-1`) completes its handshake, so packets are never interleaved. The datapath is an unregistered mux. The master side feeds an `elbuf` stage, which provides the output register and breaks the ready path.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters; legal range 2..8.
- `DW`, 33: beat width; bit `DW-1` is `last`, bits `DW-2:0` are payload.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_data`  in  `NUM_PORTS*DW`  requester beats; port i occupies bits `[i*DW +: DW]`.
- `s_valid`  in  `NUM_PORTS`  per-port valid.
- `s_ready`  out  `NUM_PORTS`  per-port ready.
- `m0_data`  out  `DW`  granted port's beat.
- `m0_valid`  out  1  granted port's valid.
- `m0_ready`  in  1  downstream ready.
- `grant`  out  `NUM_PORTS`  registered one-hot grant; all zero when idle.
- `busy`  out  1  high while a packet is locked (state LOCK).

## Operation
- Handshake: a beat transfers when `valid && ready` are both high at a rising edge. Data and valid from the upstream ports follow the usual AXI-stream rule and stay stable until accepted. The arbiter does not check this.
- State machine, two states:
  - **IDLE**:
    - `m0_valid=0`, all `s_ready=0`, `grant=0`, `busy=0`.
    - If any `s_valid` is high, the winner is the first port with `s_valid` high, scanning upward from `ptr` with wrap (`ptr`, `ptr+1`, ..., `NUM_PORTS-1`, 0, ...).
    - Register the winner one-hot into `grant` and go to LOCK.
    - If no `s_valid` is high, stay in IDLE.
  - **LOCK** (granted port g):
    - `m0_data = s_data[g]`, `m0_valid = s_valid[g]`, `s_ready[g] = m0_ready`; every other `s_ready` is 0.
    - A handshake with `m0_data[DW-1]=1` sets `ptr <= (g+1) mod NUM_PORTS` and returns to IDLE.
    - A handshake with `last=0` stays in LOCK.
- Grant is held through downstream stalls (`m0_ready=0`) and through upstream gaps (`s_valid[g]=0` mid-packet). The arbiter never re-arbitrates mid-packet and has no timeout.
- `ptr` is `clog2(NUM_PORTS)` bits. The increment wraps at `NUM_PORTS`, not at a power of two.
- Requests from ungranted ports are ignored and never dropped. Their `s_ready` stays 0 until they win.
- Reset: state IDLE, `ptr=0`, `grant=0`, `busy=0`, `m0_valid=0`, `s_ready=0`. Reset dominates every other event in the same cycle.
- Reset mid-packet abandons the packet with no flush. Downstream sees a truncated packet; higher layers handle recovery.

## Timing
- Arbitration latency: a request first visible in IDLE at edge t gives `grant` and `busy` high after edge t. The first beat can transfer at edge t+1 if `m0_ready=1`.
- Inter-packet gap: exactly one cycle in IDLE after every `last` beat. Peak throughput is n/(n+1) for n-beat packets.
- Combinational paths:
  - `m0_ready` to `s_ready[g]`.
  - `s_data[g]` and `s_valid[g]` to `m0_*`.
  - The registered `grant` selects the mux. No combinational path from any `s_valid` to `m0_valid` exists in IDLE.
- Simultaneous `last` handshake and new requests: the transition is to IDLE, and arbitration happens in the next cycle using the updated `ptr`.

## Test plan
- Single port: port 2 sends 3 beats (A, B, C with `last` on C) while `m0_ready=1`.
  - `grant=4'b0100` one cycle after `s_valid[2]` rises.
  - A, B, C appear on three consecutive cycles.
  - `busy` drops after C.
- Contention after reset: ports 0 and 1 each present a 2-beat packet in the same cycle.
  - Port 0 is served first, then one IDLE cycle, then port 1.
  - `s_ready[1]=0` throughout port 0's packet.
- Round-robin fairness: all 4 ports continuously present 1-beat packets.
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Each transfer is separated by one IDLE cycle.
- Backpressure and gaps: in a 4-beat packet from port 3, hold `m0_ready=0` for 3 cycles mid-packet, then drop `s_valid[3]` for 2 cycles.
  - `grant` stays `4'b1000` throughout.
  - `s_ready[3]` follows `m0_ready`.
  - The beat order is intact.
- Non-power-of-two wrap (`NUM_PORTS=3`): after port 2 finishes with all ports requesting, the next grant is port 0.
- Reset mid-packet: assert `reset` on beat 2 of a 4-beat packet from port 1.
  - The next cycle shows `grant=0`, `m0_valid=0`, `busy=0`.
  - After release, a new request from port 1 wins with `ptr=0` scan order.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
//
// Packet-aware round-robin arbiter sharing one stream channel between
// NUM_PORTS requesters. Once a requester wins, the grant stays locked on it
// until the beat carrying `last` (bit DW-1) completes its handshake, so
// packets from different requesters are never interleaved. After every
// packet the arbiter spends exactly one cycle in IDLE before granting again.
//
// The datapath is a plain AND-OR mux selected by the registered one-hot
// grant. There is no output register here. The downstream elbuf stage
// provides the output register and breaks the ready path.
//
// Parameters:
//   NUM_PORTS  number of requesters (2..8)
//   DW         beat width; bit DW-1 is `last`, bits DW-2:0 are payload
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   s_data     requester beats, port i at [i*DW +: DW]
//   s_valid    per-port valid
//   s_ready    per-port ready (only the granted port can see ready)
//   m0_data    granted port's beat
//   m0_valid   granted port's valid
//   m0_ready   downstream ready
//   grant      registered one-hot grant, all zero in IDLE
//   busy       high while a packet is locked
// -----------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DW        = 33
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PORTS*DW-1:0] s_data,
  input  logic [NUM_PORTS-1:0]    s_valid,
  output logic [NUM_PORTS-1:0]    s_ready,
  output logic [DW-1:0]           m0_data,
  output logic                    m0_valid,
  input  logic                    m0_ready,
  output logic [NUM_PORTS-1:0]    grant,
  output logic                    busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Constants used by the wrap-around arithmetic. The pointer wraps at
  // NUM_PORTS, not at 2**PW, so both need explicit widths.
  localparam logic [PW:0]   NP_W     = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [PW-1:0]          ptr_reg,   ptr_next;
  logic [PW-1:0]          gidx_reg,  gidx_next;
  logic [NUM_PORTS-1:0]   grant_reg, grant_next;

  logic [DW-1:0]          masked [NUM_PORTS];
  logic [PW-1:0]          win_idx;
  logic                   win_found;
  logic                   last_hs;

  // ---------------------------------------------------------------------------
  // Datapath: each port's beat is gated by its grant bit, then OR-ed.
  // grant_reg is zero in IDLE, which forces m0_valid and all s_ready low
  // without any dependency on s_valid.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
      assign masked[gi] = s_data[gi*DW +: DW] & {DW{grant_reg[gi]}};
    end
  endgenerate

  always_comb begin
    m0_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      m0_data = m0_data | masked[k];
    end
  end

  assign m0_valid = |(s_valid & grant_reg);
  assign s_ready  = grant_reg & {NUM_PORTS{m0_ready}};
  assign grant    = grant_reg;
  assign busy     = (state_reg == LOCK);

  // Handshake of the final beat of the locked packet.
  assign last_hs  = (state_reg == LOCK) && m0_valid && m0_ready && m0_data[DW-1];

  // ---------------------------------------------------------------------------
  // Winner search: scan ptr, ptr+1, ... with wrap at NUM_PORTS and take the
  // first requester found.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [PW:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr_reg} + k[PW:0];
      if (cand >= NP_W) begin
        cand = cand - NP_W;
      end
      if (!win_found && s_valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gidx_next  = gidx_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next          = LOCK;
          gidx_next           = win_idx;
          grant_next          = '0;
          grant_next[win_idx] = 1'b1;
        end
      end
      LOCK: begin
        // Stalls and upstream gaps simply hold the lock; only the last beat
        // releases it.
        if (last_hs) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = (gidx_reg == LAST_IDX) ? '0 : gidx_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      gidx_reg  <= '0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gidx_reg  <= gidx_next;
      grant_reg <= grant_next;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
//
// Directed bench for axis_rr_arbiter. A 4-port instance covers the main
// scenarios; a 3-port instance covers the non-power-of-two pointer wrap.
// Inputs are driven 1 time unit after the rising edge, outputs are checked
// 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int DW = 33;

  logic            clk;
  logic            reset;

  // 4-port instance
  logic [4*DW-1:0] s_data;
  logic [3:0]      s_valid;
  logic [3:0]      s_ready;
  logic [DW-1:0]   m0_data;
  logic            m0_valid;
  logic            m0_ready;
  logic [3:0]      grant;
  logic            busy;

  // 3-port instance
  logic [3*DW-1:0] s3_data;
  logic [2:0]      s3_valid;
  logic [2:0]      s3_ready;
  logic [DW-1:0]   m3_data;
  logic            m3_valid;
  logic            m3_ready;
  logic [2:0]      grant3;
  logic            busy3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  axis_rr_arbiter #(.NUM_PORTS(4), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m0_data  (m0_data),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .grant    (grant),
    .busy     (busy)
  );

  axis_rr_arbiter #(.NUM_PORTS(3), .DW(DW)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s3_data),
    .s_valid  (s3_valid),
    .s_ready  (s3_ready),
    .m0_data  (m3_data),
    .m0_valid (m3_valid),
    .m0_ready (m3_ready),
    .grant    (grant3),
    .busy     (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per transferred beat.
  always @(posedge clk) begin
    if (!reset && m0_valid && m0_ready)
      $display("beat4 grant=%b data=%h", grant, m0_data);
    if (!reset && m3_valid && m3_ready)
      $display("beat3 grant=%b data=%h", grant3, m3_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_port(input int p, input logic last, input logic [31:0] pl);
    s_data[p*DW +: DW] = {last, pl};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    s_valid  = '0;
    s_data   = '0;
    m0_ready = 1'b1;
    s3_valid = '0;
    s3_data  = '0;
    m3_ready = 1'b1;
    do_reset();
    settle();
    total_cnt++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
    total_cnt++; if (m0_valid !== 1'b0) $display("FAIL reset_m0_valid: got %b expected %b", m0_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (s_ready !== 4'b0000) $display("FAIL reset_s_ready: got %b expected %b", s_ready, 4'b0000); else pass_cnt++;
    total_cnt++; if (grant3 !== 3'b000) $display("FAIL reset_grant3: got %b expected %b", grant3, 3'b000); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_port();
    set_port(2, 1'b0, 32'h0000_00A1);
    s_valid = 4'b0100;
    m0_ready = 1'b1;
    settle();
    total_cnt++; if (m0_valid !== 1'b0) $display("FAIL single_idle_valid: got %b expected %b", m0_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (s_ready !== 4'b0000) $display("FAIL single_idle_ready: got %b expected %b", s_ready, 4'b0000); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b expected %b", grant, 4'b0100); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected %b", busy, 1'b1); else pass_cnt++;
    total_cnt++; if (m0_data !== {1'b0, 32'h0000_00A1}) $display("FAIL single_beat_a: got %h expected %h", m0_data, {1'b0, 32'h0000_00A1}); else pass_cnt++;
    total_cnt++; if (s_ready !== 4'b0100) $display("FAIL single_s_ready: got %b expected %b", s_ready, 4'b0100); else pass_cnt++;
    tick();
    set_port(2, 1'b0, 32'h0000_00B2);
    settle();
    total_cnt++; if (m0_data !== {1'b0, 32'h0000_00B2}) $display("FAIL single_beat_b: got %h expected %h", m0_data, {1'b0, 32'h0000_00B2}); else pass_cnt++;
    tick();
    set_port(2, 1'b1, 32'h0000_00C3);
    settle();
    total_cnt++; if (m0_data !== {1'b1, 32'h0000_00C3}) $display("FAIL single_beat_c: got %h expected %h", m0_data, {1'b1, 32'h0000_00C3}); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_c: got %b expected %b", busy, 1'b1); else pass_cnt++;
    tick();
    s_valid = 4'b0000;
    settle();
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b expected %b", busy, 1'b0); else pass_cnt++;
    total_cnt++; if (grant !== 4'b0000) $display("FAIL single_grant_drop: got %b expected %b", grant, 4'b0000); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_contention();
    do_reset();
    set_port(0, 1'b0, 32'h0000_0A00);
    set_port(1, 1'b0, 32'h0000_0B00);
    s_valid = 4'b0011;
    m0_ready = 1'b1;
    tick();
    settle();
    total_cnt++; if (grant !== 4'b0001) $display("FAIL cont_grant0: got %b expected %b", grant, 4'b0001); else pass_cnt++;
    total_cnt++; if (m0_data !== {1'b0, 32'h0000_0A00}) $display("FAIL cont_p0_beat0: got %h expected %h", m0_data, {1'b0, 32'h0000_0A00}); else pass_cnt++;
    total_cnt++; if (s_ready !== 4'b0001) $display("FAIL cont_s_ready_a: got %b expected %b", s_ready, 4'b0001); else pass_cnt++;
    tick();
    set_port(0, 1'b1, 32'h0000_0A01);
    settle();
    total_cnt++; if (m0_data !== {1'b1, 32'h0000_0A01}) $display("FAIL cont_p0_beat1: got %h expected %h", m0_data, {1'b1, 32'h0000_0A01}); else pass_cnt++;
    total_cnt++; if (s_ready !== 4'b0001) $display("FAIL cont_s_ready_b: got %b expected %b", s_ready, 4'b0001); else pass_cnt++;
    tick();
    s_valid = 4'b0010;
    settle();
    total_cnt++; if (busy !== 1'b0) $display("FAIL cont_gap_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
    total_cnt++; if (s_ready !== 4'b0000) $display("FAIL cont_gap_ready: got %b expected %b", s_ready, 4'b0000); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (grant !== 4'b0010) $display("FAIL cont_grant1: got %b expected %b", grant, 4'b0010); else pass_cnt++;
    total_cnt++; if (m0_data !== {1'b0, 32'h0000_0B00}) $display("FAIL cont_p1_beat0: got %h expected %h", m0_data, {1'b0, 32'h0000_0B00}); else pass_cnt++;
    tick();
    set_port(1, 1'b1, 32'h0000_0B01);
    settle();
    total_cnt++; if (m0_data !== {1'b1, 32'h0000_0B01}) $display("FAIL cont_p1_beat1: got %h expected %h", m0_data, {1'b1, 32'h0000_0B01}); else pass_cnt++;
    tick();
    s_valid = 4'b0000;
    settle();
    total_cnt++; if (busy !== 1'b0) $display("FAIL cont_end_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_rr_fairness();
    logic [3:0] exp_grant;
    int         exp_port;
    do_reset();
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, 32'h0000_1000 + 32'(p));
    s_valid  = 4'b1111;
    m0_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      exp_port  = r % 4;
      exp_grant = 4'b0001 << exp_port;
      tick();
      settle();
      total_cnt++; if (grant !== exp_grant) $display("FAIL rr_grant_%0d: got %b expected %b", r, grant, exp_grant); else pass_cnt++;
      total_cnt++; if (m0_data !== {1'b1, 32'h0000_1000 + 32'(exp_port)}) $display("FAIL rr_data_%0d: got %h expected %h", r, m0_data, {1'b1, 32'h0000_1000 + 32'(exp_port)}); else pass_cnt++;
      tick();
      settle();
      total_cnt++; if (busy !== 1'b0) $display("FAIL rr_gap_%0d: got %b expected %b", r, busy, 1'b0); else pass_cnt++;
    end
    s_valid = 4'b0000;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    // Pointer is 2 after the fairness run; only port 3 requests.
    set_port(3, 1'b0, 32'h0000_D000);
    s_valid  = 4'b1000;
    m0_ready = 1'b1;
    tick();
    settle();
    total_cnt++; if (grant !== 4'b1000) $display("FAIL bp_grant_start: got %b expected %b", grant, 4'b1000); else pass_cnt++;
    total_cnt++; if (m0_data !== {1'b0, 32'h0000_D000}) $display("FAIL bp_beat0: got %h expected %h", m0_data, {1'b0, 32'h0000_D000}); else pass_cnt++;
    tick();
    set_port(3, 1'b0, 32'h0000_D001);
    m0_ready = 1'b0;
    settle();
    total_cnt++; if (s_ready !== 4'b0000) $display("FAIL bp_ready_low: got %b expected %b", s_ready, 4'b0000); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      total_cnt++; if (grant !== 4'b1000) $display("FAIL bp_stall_grant_%0d: got %b expected %b", c, grant, 4'b1000); else pass_cnt++;
      total_cnt++; if (m0_data !== {1'b0, 32'h0000_D001}) $display("FAIL bp_stall_data_%0d: got %h expected %h", c, m0_data, {1'b0, 32'h0000_D001}); else pass_cnt++;
      total_cnt++; if (s_ready !== 4'b0000) $display("FAIL bp_stall_ready_%0d: got %b expected %b", c, s_ready, 4'b0000); else pass_cnt++;
    end
    m0_ready = 1'b1;
    settle();
    total_cnt++; if (s_ready !== 4'b1000) $display("FAIL bp_ready_high: got %b expected %b", s_ready, 4'b1000); else pass_cnt++;
    tick();
    set_port(3, 1'b0, 32'h0000_D002);
    s_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      settle();
      total_cnt++; if (grant !== 4'b1000) $display("FAIL bp_gap_grant_%0d: got %b expected %b", c, grant, 4'b1000); else pass_cnt++;
      total_cnt++; if (m0_valid !== 1'b0) $display("FAIL bp_gap_valid_%0d: got %b expected %b", c, m0_valid, 1'b0); else pass_cnt++;
      total_cnt++; if (s_ready !== 4'b1000) $display("FAIL bp_gap_ready_%0d: got %b expected %b", c, s_ready, 4'b1000); else pass_cnt++;
      tick();
    end
    s_valid = 4'b1000;
    settle();
    total_cnt++; if (m0_data !== {1'b0, 32'h0000_D002}) $display("FAIL bp_beat2: got %h expected %h", m0_data, {1'b0, 32'h0000_D002}); else pass_cnt++;
    total_cnt++; if (m0_valid !== 1'b1) $display("FAIL bp_beat2_valid: got %b expected %b", m0_valid, 1'b1); else pass_cnt++;
    tick();
    set_port(3, 1'b1, 32'h0000_D003);
    settle();
    total_cnt++; if (m0_data !== {1'b1, 32'h0000_D003}) $display("FAIL bp_beat3: got %h expected %h", m0_data, {1'b1, 32'h0000_D003}); else pass_cnt++;
    total_cnt++; if (grant !== 4'b1000) $display("FAIL bp_grant_last: got %b expected %b", grant, 4'b1000); else pass_cnt++;
    tick();
    s_valid = 4'b0000;
    settle();
    total_cnt++; if (grant !== 4'b0000) $display("FAIL bp_grant_end: got %b expected %b", grant, 4'b0000); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap3();
    logic [2:0] exp_grant;
    do_reset();
    for (int p = 0; p < 3; p++) s3_data[p*DW +: DW] = {1'b1, 32'h0000_3000 + 32'(p)};
    s3_valid = 3'b111;
    m3_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_grant = 3'b001 << (r % 3);
      tick();
      settle();
      total_cnt++; if (grant3 !== exp_grant) $display("FAIL wrap3_grant_%0d: got %b expected %b", r, grant3, exp_grant); else pass_cnt++;
      total_cnt++; if (m3_data !== {1'b1, 32'h0000_3000 + 32'(r % 3)}) $display("FAIL wrap3_data_%0d: got %h expected %h", r, m3_data, {1'b1, 32'h0000_3000 + 32'(r % 3)}); else pass_cnt++;
      tick();
      settle();
      total_cnt++; if (busy3 !== 1'b0) $display("FAIL wrap3_gap_%0d: got %b expected %b", r, busy3, 1'b0); else pass_cnt++;
    end
    s3_valid = 3'b000;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_packet();
    do_reset();
    m0_ready = 1'b1;
    // Port 2 completes a packet so the pointer moves to 3.
    set_port(2, 1'b1, 32'h0000_5200);
    s_valid = 4'b0100;
    tick();
    tick();
    s_valid = 4'b0000;
    tick();
    // Port 1 starts a 4-beat packet.
    set_port(1, 1'b0, 32'h0000_6100);
    s_valid = 4'b0010;
    tick();
    settle();
    total_cnt++; if (grant !== 4'b0010) $display("FAIL rst_mid_grant: got %b expected %b", grant, 4'b0010); else pass_cnt++;
    tick();
    set_port(1, 1'b0, 32'h0000_6101);
    reset = 1'b1;
    tick();
    settle();
    total_cnt++; if (grant !== 4'b0000) $display("FAIL rst_mid_grant_clr: got %b expected %b", grant, 4'b0000); else pass_cnt++;
    total_cnt++; if (m0_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected %b", m0_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
    reset = 1'b0;
    // Ports 1 and 3 request; a cleared pointer scans from 0 and picks 1.
    set_port(1, 1'b1, 32'h0000_7100);
    set_port(3, 1'b1, 32'h0000_7300);
    s_valid = 4'b1010;
    tick();
    settle();
    total_cnt++; if (grant !== 4'b0010) $display("FAIL rst_mid_new_grant: got %b expected %b", grant, 4'b0010); else pass_cnt++;
    total_cnt++; if (m0_data !== {1'b1, 32'h0000_7100}) $display("FAIL rst_mid_new_data: got %h expected %h", m0_data, {1'b1, 32'h0000_7100}); else pass_cnt++;
    tick();
    s_valid = 4'b0000;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    s_valid  = '0;
    s_data   = '0;
    m0_ready = 1'b0;
    s3_valid = '0;
    s3_data  = '0;
    m3_ready = 1'b0;
    test_reset();
    test_single_port();
    test_contention();
    test_rr_fairness();
    test_backpressure();
    test_wrap3();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
